// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-serial RAM controller between instruction fetch and load/store.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on conflicts instead of fixed LS > IF priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   input  logic              lsu_load,
   input  logic              lsu_store,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [2:0]        lsu_len,
   input  logic              lsu_signed,
   output logic              lsu_done,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mc_start,
   output logic [1:0]        mc_kind,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_wdata,
   output logic [2:0]        mc_len,
   output logic              mc_signed,
   input  logic              mc_busy,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] KIND_STORE = 2'b01;
   localparam logic [1:0] KIND_LOAD  = 2'b10;
   localparam logic [1:0] KIND_FETCH = 2'b11;

   state_t              state_q, state_d;
   logic                gnt_ls_q, gnt_ls_d;   // 1: load/store owns the controller, 0: fetch
   logic                drop_q, drop_d;
   logic                mc_start_q, mc_start_d;
   logic [1:0]          mc_kind_q, mc_kind_d;
   logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
   logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
   logic [2:0]          mc_len_q, mc_len_d;
   logic                mc_signed_q, mc_signed_d;
   logic                if_valid_q, if_valid_d;
   logic [DATA_W-1:0]   if_instr_q, if_instr_d;
   logic                lsu_done_q, lsu_done_d;
   logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

   logic ls_req, if_elig, pick_ls, issue;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_gnt_ls_q, last_gnt_ls_d;
`endif

   // Winner selection; a fetch is never eligible in the cycle a flush arrives.
   always_comb begin
      ls_req  = lsu_load | lsu_store;
      if_elig = if_req & ~if_flush;
`ifdef ARB_ROUND_ROBIN_EN
      if (ls_req && if_elig) pick_ls = ~last_gnt_ls_q;
      else                   pick_ls = ls_req;
`else
      pick_ls = ls_req;
`endif
      issue = (state_q == S_IDLE) && !mc_busy && (ls_req || if_elig);
   end

   // NOTE: every signal gets its hold/default value first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      gnt_ls_d    = gnt_ls_q;
      drop_d      = drop_q;
      mc_start_d  = 1'b0;
      mc_kind_d   = mc_kind_q;
      mc_addr_d   = mc_addr_q;
      mc_wdata_d  = mc_wdata_q;
      mc_len_d    = mc_len_q;
      mc_signed_d = mc_signed_q;
      if_valid_d  = 1'b0;
      if_instr_d  = if_instr_q;
      lsu_done_d  = 1'b0;
      lsu_rdata_d = lsu_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d    = S_WAIT;
               mc_start_d = 1'b1;
               gnt_ls_d   = pick_ls;
               drop_d     = 1'b0;
               if (pick_ls) begin
                  mc_kind_d   = lsu_store ? KIND_STORE : KIND_LOAD;
                  mc_addr_d   = lsu_addr;
                  mc_wdata_d  = lsu_wdata;
                  mc_len_d    = lsu_len;
                  mc_signed_d = lsu_signed;
               end else begin
                  mc_kind_d   = KIND_FETCH;
                  mc_addr_d   = if_addr;
                  mc_wdata_d  = '0;
                  mc_len_d    = 3'd4;
                  mc_signed_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (!gnt_ls_q && if_flush) drop_d = 1'b1;
            if (mc_done) begin
               if (gnt_ls_q) begin
                  lsu_done_d  = 1'b1;
                  lsu_rdata_d = (mc_kind_q == KIND_STORE) ? '0 : mc_rdata;
                  state_d     = S_RESP;
               end else if (!(drop_q || if_flush)) begin
                  if_valid_d = 1'b1;
                  if_instr_d = mc_rdata;
                  state_d    = S_RESP;
               end else begin
                  // A flushed fetch completes silently and skips the response cycle.
                  state_d = S_IDLE;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         gnt_ls_q    <= 1'b0;
         drop_q      <= 1'b0;
         mc_start_q  <= 1'b0;
         mc_kind_q   <= '0;
         mc_addr_q   <= '0;
         mc_wdata_q  <= '0;
         mc_len_q    <= '0;
         mc_signed_q <= 1'b0;
         if_valid_q  <= 1'b0;
         if_instr_q  <= '0;
         lsu_done_q  <= 1'b0;
         lsu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_ls_q    <= gnt_ls_d;
         drop_q      <= drop_d;
         mc_start_q  <= mc_start_d;
         mc_kind_q   <= mc_kind_d;
         mc_addr_q   <= mc_addr_d;
         mc_wdata_q  <= mc_wdata_d;
         mc_len_q    <= mc_len_d;
         mc_signed_q <= mc_signed_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         lsu_done_q  <= lsu_done_d;
         lsu_rdata_q <= lsu_rdata_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      last_gnt_ls_d = last_gnt_ls_q;
      if (issue) last_gnt_ls_d = pick_ls;
   end

   always_ff @(posedge clk) begin
      if (rst) last_gnt_ls_q <= 1'b0;
      else     last_gnt_ls_q <= last_gnt_ls_d;
   end
`endif

   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign lsu_done  = lsu_done_q;
   assign lsu_rdata = lsu_rdata_q;
   assign mc_start  = mc_start_q;
   assign mc_kind   = mc_kind_q;
   assign mc_addr   = mc_addr_q;
   assign mc_wdata  = mc_wdata_q;
   assign mc_len    = mc_len_q;
   assign mc_signed = mc_signed_q;

endmodule
